// File: rtl/pattern_counter.sv
// Phased pattern detector: each phase accepts one or more copies of its symbol;
// reports the matched state, a one-cycle hit pulse and a saturating match count.
module pattern_counter #(
  parameter int W      = 2,
  parameter int PHASES = 3,
  parameter int CNT_W  = 8,
  localparam int PW    = $clog2(PHASES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [W-1:0]        num,
  input  logic [PHASES*W-1:0] pattern,
  input  logic                clr_cnt,
  output logic                ans,
  output logic                hit,
  output logic [CNT_W-1:0]    count,
  output logic [PW-1:0]       phase
);

  localparam logic [PW-1:0]    S_MATCH = PW'(PHASES);
  localparam logic [PW-1:0]    S_LAST  = PW'(PHASES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [PW-1:0] s, s_next;
  logic [W-1:0]  cur_sym, prev_sym, first_sym;
  logic          adv, rep, match;

  // Handshake: num is consumed on a rising edge only when in_valid is high;
  // there is no backpressure, so every valid symbol is accepted.

  always_comb begin
    cur_sym   = '0;
    prev_sym  = '0;
    first_sym = pattern[W-1:0];
    for (int k = 0; k < PHASES; k++) begin
      if (PW'(k) == s)           cur_sym  = pattern[k*W +: W];
      if (PW'(k) + PW'(1) == s)  prev_sym = pattern[k*W +: W];
    end
  end

  // Advance beats repeat so equal adjacent symbols still make progress.
  always_comb begin
    adv    = (s < S_MATCH) && (num == cur_sym);
    rep    = (s != '0) && (num == prev_sym);
    s_next = s;
    if (in_valid) begin
      if (adv)                   s_next = s + PW'(1);
      else if (rep)              s_next = s;
      else if (num == first_sym) s_next = PW'(1);
      else                       s_next = '0;
    end
    match = in_valid && adv && (s == S_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s     <= '0;
      hit   <= 1'b0;
      count <= '0;
    end else begin
      s   <= s_next;
      hit <= match;
      if (clr_cnt)
        count <= match ? CNT_W'(1) : '0;
      else if (match && count != CNT_MAX)
        count <= count + CNT_W'(1);
    end
  end

  assign ans   = (s == S_MATCH);
  assign phase = s;

endmodule

// File: tb/tb_pattern_counter.sv
// Directed bench for pattern_counter (W=2, PHASES=3); a second instance with
// CNT_W=2 shares the stimulus to exercise count saturation.
module tb_pattern_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] num = 2'b00;
  logic [5:0] pattern = 6'b111001;
  logic       clr_cnt = 1'b0;

  logic       ans, hit, ans2, hit2;
  logic [7:0] count;
  logic [1:0] count2;
  logic [1:0] phase, phase2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pattern_counter #(.W(2), .PHASES(3), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num), .pattern(pattern),
    .clr_cnt(clr_cnt), .ans(ans), .hit(hit), .count(count), .phase(phase)
  );

  pattern_counter #(.W(2), .PHASES(3), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .num(num), .pattern(pattern),
    .clr_cnt(clr_cnt), .ans(ans2), .hit(hit2), .count(count2), .phase(phase2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic v, input logic [1:0] n, input logic c);
    in_valid = v;
    num      = n;
    clr_cnt  = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b1, 2'b01, 1'b1);
    reset = 1'b0;
  endtask

  task automatic full_match();
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
  endtask

  logic [1:0] seq27 [7] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11};
  logic [1:0] ph27  [7] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] cnt30 [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

  initial begin
    // Reset state
    do_reset();
    chk("rst_phase", phase, 0);
    chk("rst_ans", ans, 0);
    chk("rst_hit", hit, 0);
    chk("rst_count", count, 0);
    chk("rst_count2", count2, 0);

    // Basic match
    cyc(1'b1, 2'b01, 1'b0);
    chk("basic_ph1", phase, 1);
    cyc(1'b1, 2'b10, 1'b0);
    chk("basic_ph2", phase, 2);
    chk("basic_ans_early", ans, 0);
    cyc(1'b1, 2'b11, 1'b0);
    chk("basic_ph3", phase, 3);
    chk("basic_ans", ans, 1);
    chk("basic_hit", hit, 1);
    chk("basic_count", count, 1);
    cyc(1'b0, 2'b00, 1'b0);
    chk("basic_hit_drop", hit, 0);
    chk("basic_ans_hold", ans, 1);

    // Repeated symbols in each phase
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, seq27[i], 1'b0);
      chk($sformatf("rep_phase%0d", i), phase, ph27[i]);
      chk($sformatf("rep_hit%0d", i), hit, (i == 4) ? 1 : 0);
      if (i >= 4) chk($sformatf("rep_ans%0d", i), ans, 1);
    end
    chk("rep_count", count, 1);

    // Restart from matched state
    cyc(1'b1, 2'b01, 1'b0);
    chk("restart_phase", phase, 1);
    chk("restart_ans", ans, 0);
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    chk("restart_hit", hit, 1);
    chk("restart_count", count, 2);

    // Invalid gaps are ignored
    do_reset();
    cyc(1'b1, 2'b01, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 2'b00, 1'b0);
      chk($sformatf("gap_phase%0d", i), phase, 1);
      chk($sformatf("gap_hit%0d", i), hit, 0);
    end
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b11, 1'b0);
    chk("gap_hit", hit, 1);
    chk("gap_count", count, 1);

    // Mismatch drops to idle
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b00, 1'b0);
    chk("miss_phase", phase, 0);

    // Saturation on the narrow counter, then clear on a match edge
    do_reset();
    for (int i = 0; i < 4; i++) begin
      full_match();
      chk($sformatf("sat_count2_%0d", i), count2, cnt30[i]);
    end
    chk("sat_count_wide", count, 4);
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    cyc(1'b1, 2'b11, 1'b1);
    chk("clr_match_count2", count2, 1);
    chk("clr_match_count", count, 1);
    chk("clr_match_hit", hit, 1);
    cyc(1'b0, 2'b00, 1'b1);
    chk("clr_only_count", count, 0);

    // Reset mid-sequence
    do_reset();
    cyc(1'b1, 2'b01, 1'b0);
    cyc(1'b1, 2'b10, 1'b0);
    do_reset();
    chk("midrst_phase", phase, 0);
    cyc(1'b1, 2'b11, 1'b0);
    chk("midrst_phase_after", phase, 0);
    chk("midrst_hit", hit, 0);
    chk("midrst_count", count, 0);

    // Pattern change keeps state; advance beats repeat for equal neighbours
    do_reset();
    cyc(1'b1, 2'b01, 1'b0);
    pattern = 6'b110101;
    cyc(1'b0, 2'b00, 1'b0);
    chk("patchg_keep", phase, 1);
    cyc(1'b1, 2'b01, 1'b0);
    chk("patchg_adv", phase, 2);
    cyc(1'b1, 2'b11, 1'b0);
    chk("patchg_match", phase, 3);
    chk("patchg_hit", hit, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_counter.md
PATTERN_COUNTER -- requirements
Module: pattern_counter

Interface
REQ-001 SHALL have parameter W, default 2: symbol width in bits.
REQ-002 SHALL have parameter PHASES, default 3: number of pattern phases; legal range 2..16.
REQ-003 SHALL have parameter CNT_W, default 8: match counter width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: num is consumed this cycle when high.
REQ-007 SHALL have port num, input, W: input symbol.
REQ-008 SHALL have port pattern, input, PHASES*W: phase k symbol P[k] = pattern[k*W +: W].
REQ-009 SHALL have port clr_cnt, input, 1: synchronous clear of count.
REQ-010 SHALL have port ans, output, 1: high while the full pattern is matched.
REQ-011 SHALL have port hit, output, 1: one-cycle pulse on each new match.
REQ-012 SHALL have port count, output, CNT_W: saturating number of matches.
REQ-013 SHALL have port phase, output, clog2(PHASES+1): current state s.

Function
REQ-014 SHALL hold state s in 0..PHASES: 0 = idle; s = number of phases matched; s = PHASES = matched.
- Each phase accepts one or more consecutive copies of its symbol.
REQ-015 SHALL, on a valid cycle with symbol x, pick the next state from the first rule that applies:
- (a) s<PHASES and x==P[s] -> s+1.
- (b) s>0 and x==P[s-1] -> s (repeat).
- (c) x==P[0] -> 1 (restart).
- (d) otherwise -> 0.
REQ-016 SHALL keep s, and hold hit at 0, on any cycle with in_valid low; num is ignored.
REQ-017 SHALL drive ans = (s==PHASES) directly from the state register, with no extra latency.
REQ-018 SHALL assert hit for exactly the cycle after a PHASES-1 -> PHASES transition; a repeat in the matched state SHALL NOT pulse hit.
REQ-019 SHALL increment count on the same edge that makes s equal PHASES, and saturate at 2^CNT_W-1 (no wrap).
REQ-020 SHALL, when clr_cnt is high, load count with 0; if a match also occurs on that edge, load 1.
REQ-021 SHALL sample pattern every cycle; a change in pattern takes effect immediately and SHALL NOT reset s.
REQ-022 SHALL give rule (a) priority over rule (b) when adjacent phases carry equal symbols.
REQ-023 SHALL register all outputs except ans, which is decoded from registered state.

Reset
REQ-024 SHALL, on a clk edge with reset high, set s=0, ans=0, hit=0, count=0, overriding in_valid and clr_cnt.
REQ-025 SHALL, on reset mid-sequence, discard partial progress; matching restarts from phase 0 on the next valid symbol.

Verification (W=2, PHASES=3, pattern=6'b111001, i.e. P0=01, P1=10, P2=11)
REQ-026 SHALL cover: valid 01,10,11 on consecutive edges -> phase 1,2,3; ans=1 after edge 3; hit=1 for one cycle; count=1.
REQ-027 SHALL cover: 01,01,10,10,11,11,11 -> phase 1,1,2,2,3,3,3; one hit; count=1; ans stays high after edges 5-7.
REQ-028 SHALL cover: from matched, 01 -> phase 1, ans=0; then 10,11 -> second hit; count=2.
REQ-029 SHALL cover: 01, then in_valid=0 for 3 cycles with num=00, then 10,11 -> gaps ignored; hit; count=1.
REQ-030 SHALL cover: with CNT_W=2, four full matches -> count 1,2,3,3; then clr_cnt on a match edge -> count=1.
REQ-031 SHALL cover: 01,10 then reset, then 11 -> phase 0 after reset; no hit; count=0.
